// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Sequential instruction fetch with a 2-entry {pc, instr} output
//             buffer, redirect/flush handling and a sticky misalign flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Architectural state: PC, occupancy and two buffer slots (slot 0 is head)
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, instr0_q, instr0_d;
  logic [31:0] pc1_q, pc1_d, instr1_q, instr1_d;
  logic        misalign_q, misalign_d;

  logic w_pop;
  logic w_fetch;

  // Handshake and fetch decisions; out_valid depends on registered count only
  always_comb begin
    out_valid = (count_q != 2'd0);
    w_pop     = out_valid && out_ready;
    w_fetch   = !redirect_valid && ((count_q < 2'd2) || w_pop);
  end

  // Output drive: head entry, or NOP at address 0 when the buffer is empty
  always_comb begin
    imem_addr    = pc_q;
    misalign_err = misalign_q;
    if (count_q != 2'd0) begin
      out_instr = instr0_q;
      out_pc    = pc0_q;
    end else begin
      out_instr = NOP_INSTR;
      out_pc    = 32'h0000_0000;
    end
  end

  // Next-state: flush on redirect, otherwise in-order push/pop of the buffer
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    instr0_d   = instr0_q;
    pc1_d      = pc1_q;
    instr1_d   = instr1_q;
    misalign_d = misalign_q;

    if (redirect_valid) begin
      // Flush dominates; a pop in this cycle is simply dropped from the buffer
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (w_fetch) begin
        pc_d = pc_q + 32'd4;
      end
      unique case ({w_fetch, w_pop})
        2'b10: begin
          // Push only: fill the first free slot
          if (count_q == 2'd0) begin
            pc0_d    = pc_q;
            instr0_d = imem_rdata;
          end else begin
            pc1_d    = pc_q;
            instr1_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Pop only: advance slot 1 into the head
          pc0_d    = pc1_q;
          instr0_d = instr1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Push and pop together: occupancy unchanged, order preserved
          if (count_q == 2'd1) begin
            pc0_d    = pc_q;
            instr0_d = imem_rdata;
          end else begin
            pc0_d    = pc1_q;
            instr0_d = instr1_q;
            pc1_d    = pc_q;
            instr1_d = imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with asynchronous reset back to RESET_PC and an empty buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      pc0_q      <= 32'h0000_0000;
      instr0_q   <= 32'h0000_0000;
      pc1_q      <= 32'h0000_0000;
      instr1_q   <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      instr0_q   <= instr0_d;
      pc1_q      <= pc1_d;
      instr1_q   <= instr1_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr  output  32  the fetch byte address driven to instruction memory; equals the PC register.
REQ-005 SHALL have port imem_rdata  input  32  the instruction word returned combinationally, in the same cycle, for imem_addr.
REQ-006 SHALL have port redirect_valid  input  1  a branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  the redirect target address.
REQ-008 SHALL have port out_valid  output  1  the buffer head holds a valid instruction.
REQ-009 SHALL have port out_ready  input  1  the decode stage accepts the head entry.
REQ-010 SHALL have port out_instr  output  32  the head instruction word.
REQ-011 SHALL have port out_pc  output  32  the address the head instruction was fetched from.
REQ-012 SHALL have port misalign_err  output  1  sticky flag: a misaligned redirect was received.

Function
REQ-013 SHALL hold a 2-entry in-order buffer of {pc, instr} pairs with an occupancy count of 0..2.
REQ-014 SHALL compute pop = out_valid && out_ready.
REQ-015 SHALL compute fetch = !redirect_valid && (count < 2 || pop).
REQ-016 On fetch, SHALL push {imem_addr, imem_rdata} at the tail and set PC <= PC + 4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-017 When no fetch occurs and there is no redirect, SHALL hold the PC.
REQ-018 SHALL raise out_valid whenever count != 0, derived from registered state only, with no combinational path from redirect_valid.
REQ-019 SHALL drive out_instr and out_pc from the head entry; when empty, SHALL drive out_instr = 32'h00000013 (NOP) and out_pc = 0.
REQ-020 Simultaneous push and pop with count == 2 SHALL keep count at 2, preserving order.
REQ-021 Simultaneous push and pop with count == 1 SHALL keep count at 1, with the new entry becoming the head.
REQ-022 SHALL never overflow (push only when a slot is free or freed this cycle) and never underflow (pop only when valid).
REQ-023 On redirect_valid, at the next edge SHALL set count <= 0 (flush) and PC <= {redirect_pc[31:2], 2'b00}, with no push that cycle.
REQ-024 A pop in the redirect cycle SHALL count as a completed transfer; flush dominates any other buffer update.
REQ-025 SHALL set misalign_err on any edge where redirect_valid = 1 and redirect_pc[1:0] != 0; only reset SHALL clear it.
REQ-026 Steady state with out_ready = 1 SHALL deliver one instruction per cycle.
REQ-027 The first instruction SHALL be valid one edge after reset deassertion.

Reset
REQ-028 While reset = 1, asynchronously and immediately: PC = RESET_PC, imem_addr = RESET_PC, count = 0, out_valid = 0, out_instr = 32'h00000013, out_pc = 0, misalign_err = 0.
REQ-029 Reset asserted mid-operation (stalled, full, or redirecting) SHALL discard all buffered entries with no pending output.
REQ-030 After reset deasserts, SHALL resume fetching from RESET_PC.

Verification
REQ-031 Bench SHALL cover: RESET_PC = 0, imem_rdata = address-tagged words, out_ready = 1 -> out_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, each out_instr matching its tag.
REQ-032 Bench SHALL cover: out_ready = 0 for 5 cycles after reset -> count = 2, imem_addr holds 0x8, out_pc holds 0x0; out_ready = 1 -> 0x0, 0x4, 0x8 in order with no loss or duplication.
REQ-033 Bench SHALL cover: redirect_valid = 1, redirect_pc = 0x40 while full -> next cycle out_valid = 0 and imem_addr = 0x40; the cycle after, out_pc = 0x40.
REQ-034 Bench SHALL cover: redirect_pc = 0x43 -> PC = 0x40 and misalign_err = 1, still 1 after 10 further cycles, cleared only by reset.
REQ-035 Bench SHALL cover: redirect_pc = 0xFFFFFFFC, out_ready = 1 -> out_pc 0xFFFFFFFC then 0x00000000.
REQ-036 Bench SHALL cover: reset asserted between clock edges while stalled and full -> out_valid = 0 and imem_addr = RESET_PC before the next edge.
